// File: rtl/fetch_pkg.sv
// Shared fetch-side constants and helpers for the instruction prefetch path.
package fetch_pkg;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  // Credit counters need headroom above DEPTH so sums never wrap.
  function automatic int cntWidth(input int depth);
    return $clog2(depth + 1) + 1;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// In-order FIFO with synchronous clear; head is read straight from the storage array.
// Clear wins over push/pop; a push is honoured when full only if a pop frees a slot that cycle.
module sync_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push,
  input  logic [WIDTH-1:0]             pushData,
  input  logic                         pop,
  output logic [WIDTH-1:0]             popData,
  input  logic                         clear,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int AW  = $clog2(DEPTH);
  localparam int CNT = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wrPtr;
  logic [AW-1:0]    rdPtr;
  logic             doPush;
  logic             doPop;

  assign empty   = (count == '0);
  assign full    = (count == CNT'(DEPTH));
  assign doPop   = pop && !empty;
  assign doPush  = push && (!full || doPop);
  assign popData = mem[rdPtr];

  always_ff @(posedge clk) begin
    if (rst_n || clear) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + 1'b1;
      if (doPop)  rdPtr <= rdPtr + 1'b1;
      count <= count + CNT'(doPush) - CNT'(doPop);
    end
  end

  always_ff @(posedge clk) begin
    if (doPush && !clear && !rst_n) mem[wrPtr] <= pushData;
  end

endmodule

// File: rtl/instr_prefetch_buffer.sv
// Sequential instruction prefetcher: redirect-to-instr_valid is 3 cycles with 1-cycle memory.
// Issue is credit-limited by buffered + live + stale requests; stall holds the FIFO contents.
module instr_prefetch_buffer
  import fetch_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        stall,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        mem_req_valid,
  output logic [31:0] mem_req_addr,
  input  logic        mem_req_ready,
  input  logic        mem_resp_valid,
  input  logic [31:0] mem_resp_data
);

  localparam int CW  = cntWidth(DEPTH);
  localparam int FCW = $clog2(DEPTH + 1);

  logic [31:0]    fetchPc;
  logic [31:0]    respPc;
  logic [31:0]    redirectAligned;
  logic [CW-1:0]  outstanding;
  logic [CW-1:0]  dropCnt;
  logic [CW:0]    creditUse;
  logic [FCW-1:0] fifoCount;
  logic           fifoEmpty;
  logic           fifoFull;
  logic [63:0]    fifoHead;
  logic           reqFire;
  logic           respLive;
  logic           respDrop;
  logic           doPop;

  assign redirectAligned = redirect_pc & ~32'h3;
  assign creditUse = (CW+1)'(fifoCount) + (CW+1)'(outstanding) + (CW+1)'(dropCnt);

  assign mem_req_valid = !rst_n && !redirect_valid && (creditUse < (CW+1)'(DEPTH));
  assign mem_req_addr  = fetchPc;
  assign reqFire       = mem_req_valid && mem_req_ready;

  assign respDrop = mem_resp_valid && (dropCnt != '0);
  assign respLive = mem_resp_valid && (dropCnt == '0) && (outstanding != '0);

  assign instr_valid = !rst_n && !fifoEmpty;
  assign instr       = instr_valid ? fifoHead[31:0]  : 32'h0;
  assign instr_pc    = instr_valid ? fifoHead[63:32] : 32'h0;
  assign doPop       = instr_valid && !stall && !redirect_valid;

  always_ff @(posedge clk) begin
    if (rst_n) begin
      fetchPc     <= RESET_PC;
      respPc      <= RESET_PC;
      outstanding <= '0;
      dropCnt     <= '0;
    end else if (redirect_valid) begin
      // Whatever is still in flight after this cycle's response becomes stale.
      fetchPc     <= redirectAligned;
      respPc      <= redirectAligned;
      outstanding <= '0;
      dropCnt     <= dropCnt - CW'(respDrop) + outstanding - CW'(respLive);
    end else begin
      if (reqFire)  fetchPc <= fetchPc + 32'd4;
      if (respLive) respPc  <= respPc + 32'd4;
      outstanding <= outstanding + CW'(reqFire) - CW'(respLive);
      dropCnt     <= dropCnt - CW'(respDrop);
    end
  end

  sync_fifo #(
    .DEPTH(DEPTH),
    .WIDTH(64)
  ) uFifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (respLive && !redirect_valid),
    .pushData ({respPc, mem_resp_data}),
    .pop      (doPop),
    .popData  (fifoHead),
    .clear    (redirect_valid),
    .full     (fifoFull),
    .empty    (fifoEmpty),
    .count    (fifoCount)
  );

  respProtocol: assert property (@(posedge clk) disable iff (rst_n)
    !(mem_resp_valid && (outstanding == '0) && (dropCnt == '0)));

  pushNeverFull: assert property (@(posedge clk) disable iff (rst_n)
    !(respLive && fifoFull && !doPop));

endmodule

// File: tb/tb_instr_prefetch_buffer.sv
// Directed bench for the prefetch buffer: in-order memory model plus an instruction scoreboard.
module tb_instr_prefetch_buffer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        stall;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        mem_req_valid;
  logic [31:0] mem_req_addr;
  logic        mem_req_ready;
  logic        mem_resp_valid = 1'b0;
  logic [31:0] mem_resp_data  = 32'h0;

  int checks = 0;
  int errors = 0;
  int popCnt = 0;
  int reqCnt = 0;
  int cyc    = 0;
  int memLat = 1;

  logic [31:0] expPc [$];
  logic [31:0] mAddr [$];
  int          mDue  [$];

  instr_prefetch_buffer #(.DEPTH(4), .RESET_PC(32'h0)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .stall          (stall),
    .instr_valid    (instr_valid),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .mem_req_valid  (mem_req_valid),
    .mem_req_addr   (mem_req_addr),
    .mem_req_ready  (mem_req_ready),
    .mem_resp_valid (mem_resp_valid),
    .mem_resp_data  (mem_resp_data)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] memWord(input logic [31:0] a);
    return a ^ 32'h5A5A_0013;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic expectRun(input logic [31:0] start, input int n);
    for (int i = 0; i < n; i++) expPc.push_back(start + 32'(4 * i));
  endtask

  task automatic waitPops(input int n, output int waited);
    int base;
    base   = popCnt;
    waited = 0;
    while (popCnt < base + n && waited < 300) begin
      @(negedge clk);
      waited++;
    end
    check("pop_budget", 32'(popCnt - base), 32'(n));
  endtask

  // In-order memory: accept at posedge, present the response memLat cycles later.
  always @(posedge clk) begin
    cyc++;
    if (rst_n) begin
      mAddr.delete();
      mDue.delete();
    end else begin
      if (mem_resp_valid && mAddr.size() > 0) begin
        void'(mAddr.pop_front());
        void'(mDue.pop_front());
      end
      if (mem_req_valid && mem_req_ready) begin
        mAddr.push_back(mem_req_addr);
        mDue.push_back(cyc + memLat - 1);
        reqCnt++;
      end
    end
  end

  always @(negedge clk) begin
    if (mAddr.size() > 0 && mDue[0] <= cyc) begin
      mem_resp_valid = 1'b1;
      mem_resp_data  = memWord(mAddr[0]);
    end else begin
      mem_resp_valid = 1'b0;
      mem_resp_data  = 32'h0;
    end
  end

  // Scoreboard monitor: every instruction the pipeline accepts must match the queue head.
  always @(posedge clk) begin
    if (instr_valid && !stall && !redirect_valid) begin
      popCnt++;
      if (expPc.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_instr actual_pc=%h required=none", instr_pc);
      end else begin
        logic [31:0] e;
        e = expPc.pop_front();
        check("instr_pc", instr_pc, e);
        check("instr_word", instr, memWord(e));
      end
    end
  end

  initial begin
    int waited;
    int r0;
    rst_n          = 1'b1;
    stall          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    mem_req_ready  = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_instr_valid", instr_valid, 0);
    check("rst_req_valid", mem_req_valid, 0);
    check("rst_instr", instr, 0);
    check("rst_instr_pc", instr_pc, 0);

    // Streaming with 1-cycle memory, then a reset in the middle of it.
    expectRun(32'h0, 8);
    rst_n = 1'b0;
    #1;
    check("first_req_valid", mem_req_valid, 1);
    check("first_req_addr", mem_req_addr, 32'h0);
    @(negedge clk);
    check("lat1_instr_valid", instr_valid, 0);
    @(negedge clk);
    check("lat2_instr_valid", instr_valid, 1);
    check("lat2_instr_pc", instr_pc, 32'h0);
    waitPops(8, waited);
    check("throughput_cycles", 32'(waited), 32'd8);
    rst_n = 1'b1;
    #1;
    check("midrst_req_valid", mem_req_valid, 0);
    @(negedge clk);
    check("midrst_instr_valid", instr_valid, 0);
    check("midrst_req_valid2", mem_req_valid, 0);
    check("midrst_instr_pc", instr_pc, 0);
    check("sb_drain_1", 32'(expPc.size()), 0);

    // Restart under stall: credits cap issue at four requests.
    stall = 1'b1;
    rst_n = 1'b0;
    r0    = reqCnt;
    repeat (10) @(negedge clk);
    check("stall_req_count", 32'(reqCnt - r0), 32'd4);
    check("stall_req_valid", mem_req_valid, 0);
    check("stall_instr_valid", instr_valid, 1);
    check("stall_head_pc", instr_pc, 32'h0);
    expectRun(32'h0, 8);
    stall = 1'b0;
    waitPops(8, waited);
    stall = 1'b1;
    repeat (6) @(negedge clk);

    // 3-cycle memory: three requests in flight when redirected to 0x100.
    memLat         = 3;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h40;
    r0             = reqCnt;
    #1;
    check("redir_no_req", mem_req_valid, 0);
    @(negedge clk);
    redirect_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("outstanding_three", 32'(reqCnt - r0), 32'd3);
    check("none_returned", instr_valid, 0);
    expectRun(32'h100, 8);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h100;
    @(negedge clk);
    redirect_valid = 1'b0;
    stall          = 1'b0;
    waitPops(8, waited);
    stall = 1'b1;
    repeat (6) @(negedge clk);

    // Redirect coinciding with a live response and a would-be pop.
    memLat = 1;
    expectRun(32'h120, 8);
    stall = 1'b0;
    waitPops(8, waited);
    check("pre_redir_valid", instr_valid, 1);
    expectRun(32'h300, 8);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h300;
    @(negedge clk);
    redirect_valid = 1'b0;
    check("flush_empty", instr_valid, 0);
    waitPops(8, waited);
    stall = 1'b1;
    repeat (6) @(negedge clk);

    // Memory not ready: request must hold; a misaligned redirect lands aligned.
    mem_req_ready  = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h400;
    #1;
    check("redir_withdraw", mem_req_valid, 0);
    @(negedge clk);
    redirect_valid = 1'b0;
    #1;
    for (int i = 0; i < 5; i++) begin
      check("hold_valid", mem_req_valid, 1);
      check("hold_addr", mem_req_addr, 32'h400);
      @(negedge clk);
      #1;
    end
    redirect_valid = 1'b1;
    redirect_pc    = 32'h203;
    @(negedge clk);
    redirect_valid = 1'b0;
    #1;
    check("align_valid", mem_req_valid, 1);
    check("align_addr", mem_req_addr, 32'h200);
    @(negedge clk);
    #1;
    check("align_hold", mem_req_addr, 32'h200);
    expectRun(32'h200, 8);
    mem_req_ready = 1'b1;
    stall         = 1'b0;
    waitPops(8, waited);
    stall = 1'b1;
    repeat (8) @(negedge clk);
    check("sb_final", 32'(expPc.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
